// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator (hsync, vsync,
// display_on, pixel coordinates, line/frame strobes, frame counter).
// Optional feature macro: VTG_RUNTIME_CFG_EN enables the frame-synchronous
// runtime reconfiguration port. When it is undefined, the timing is fixed by
// the parameters, cfg_ready and cfg_err read 0, and the cfg_* inputs are ignored.
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int FCW      = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            hsync,
  output logic            vsync,
  output logic            display_on,
  output logic [CW-1:0]   hpos,
  output logic [CW-1:0]   vpos,
  output logic            line_start,
  output logic            frame_start,
  output logic [FCW-1:0]  frame_cnt,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [4*CW-1:0] cfg_h,
  input  logic [4*CW-1:0] cfg_v,
  input  logic [1:0]      cfg_pol,
  output logic            cfg_err
);

  localparam logic [CW-1:0] P_HA     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] P_HFP    = CW'(H_FP);
  localparam logic [CW-1:0] P_HS     = CW'(H_SYNC);
  localparam logic [CW-1:0] P_HBP    = CW'(H_BP);
  localparam logic [CW-1:0] P_VA     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] P_VFP    = CW'(V_FP);
  localparam logic [CW-1:0] P_VS     = CW'(V_SYNC);
  localparam logic [CW-1:0] P_VBP    = CW'(V_BP);
  localparam logic          P_HS_POL = (HS_POL != 0);
  localparam logic          P_VS_POL = (VS_POL != 0);
  localparam logic [CW-1:0] P_ONE    = CW'(1);

  // Active timing set, packed {active, fp, sync, bp}
  logic [4*CW-1:0] w_h_set, w_v_set;
  logic            w_hs_pol, w_vs_pol;
  logic [CW-1:0]   w_ha, w_hfp, w_hs, w_hbp, w_va, w_vfp, w_vs, w_vbp;
  logic [CW-1:0]   w_ht, w_vt;
  logic [CW-1:0]   r_h_cnt, r_v_cnt;
  logic            w_h_last, w_v_last, w_frame_end, w_origin;
  logic            w_in_hs, w_in_vs;

  assign {w_ha, w_hfp, w_hs, w_hbp} = w_h_set;
  assign {w_va, w_vfp, w_vs, w_vbp} = w_v_set;
  // Accepted sets always have totals below 2^CW, so CW-bit sums cannot wrap
  assign w_ht        = w_ha + w_hfp + w_hs + w_hbp;
  assign w_vt        = w_va + w_vfp + w_vs + w_vbp;
  assign w_h_last    = (r_h_cnt == w_ht - P_ONE);
  assign w_v_last    = (r_v_cnt == w_vt - P_ONE);
  assign w_frame_end = w_h_last && w_v_last;
  assign w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_in_hs     = (r_h_cnt >= w_ha + w_hfp) && (r_h_cnt < w_ha + w_hfp + w_hs);
  assign w_in_vs     = (r_v_cnt >= w_va + w_vfp) && (r_v_cnt < w_va + w_vfp + w_vs);

`ifdef VTG_RUNTIME_CFG_EN
  // Handshake: a set is taken when cfg_valid && cfg_ready at a rising edge;
  // cfg_ready stays low while a set is pending and rises at the frame end
  // where that set is either applied or rejected (cfg_err pulses on reject).
  logic [4*CW-1:0] r_h_act, r_v_act, r_h_pend, r_v_pend;
  logic [1:0]      r_pol_act, r_pol_pend;
  logic            r_pend_vld, r_cfg_err;
  logic [CW+1:0]   w_cfg_ht, w_cfg_vt;
  logic            w_cfg_ok;

  assign w_cfg_ht = (CW+2)'(r_h_pend[4*CW-1 -: CW]) + (CW+2)'(r_h_pend[3*CW-1 -: CW])
                  + (CW+2)'(r_h_pend[2*CW-1 -: CW]) + (CW+2)'(r_h_pend[CW-1 -: CW]);
  assign w_cfg_vt = (CW+2)'(r_v_pend[4*CW-1 -: CW]) + (CW+2)'(r_v_pend[3*CW-1 -: CW])
                  + (CW+2)'(r_v_pend[2*CW-1 -: CW]) + (CW+2)'(r_v_pend[CW-1 -: CW]);
  assign w_cfg_ok = (r_h_pend[4*CW-1 -: CW] != '0) && (r_h_pend[2*CW-1 -: CW] != '0)
                 && (r_v_pend[4*CW-1 -: CW] != '0) && (r_v_pend[2*CW-1 -: CW] != '0)
                 && (w_cfg_ht[CW+1:CW] == 2'b00) && (w_cfg_vt[CW+1:CW] == 2'b00);

  // Capture offered sets; validate and switch only at the last pixel of a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_act    <= {P_HA, P_HFP, P_HS, P_HBP};
      r_v_act    <= {P_VA, P_VFP, P_VS, P_VBP};
      r_pol_act  <= {P_HS_POL, P_VS_POL};
      r_h_pend   <= '0;
      r_v_pend   <= '0;
      r_pol_pend <= '0;
      r_pend_vld <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (w_frame_end && r_pend_vld) begin
        if (w_cfg_ok) begin
          r_h_act   <= r_h_pend;
          r_v_act   <= r_v_pend;
          r_pol_act <= r_pol_pend;
        end
        r_cfg_err  <= !w_cfg_ok;
        r_pend_vld <= 1'b0;
      end else if (cfg_valid && !r_pend_vld) begin
        r_h_pend   <= cfg_h;
        r_v_pend   <= cfg_v;
        r_pol_pend <= cfg_pol;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign w_h_set   = r_h_act;
  assign w_v_set   = r_v_act;
  assign w_hs_pol  = r_pol_act[1];
  assign w_vs_pol  = r_pol_act[0];
  assign cfg_ready = !r_pend_vld;
  assign cfg_err   = r_cfg_err;
`else
  logic w_unused_cfg;

  assign w_h_set      = {P_HA, P_HFP, P_HS, P_HBP};
  assign w_v_set      = {P_VA, P_VFP, P_VS, P_VBP};
  assign w_hs_pol     = P_HS_POL;
  assign w_vs_pol     = P_VS_POL;
  assign cfg_ready    = 1'b0;
  assign cfg_err      = 1'b0;
  assign w_unused_cfg = ^{cfg_valid, cfg_h, cfg_v, cfg_pol};
`endif

  // Raster position counters: h wraps at HT-1, v advances on each h wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + P_ONE;
    end else begin
      r_h_cnt <= r_h_cnt + P_ONE;
    end
  end

  logic            r_hsync, r_vsync, r_display_on, r_line_start, r_frame_start, r_first;
  logic [CW-1:0]   r_hpos, r_vpos;
  logic [FCW-1:0]  r_frame_cnt;

  // Registered decode of the current position; all outputs share one stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync       <= !P_HS_POL;
      r_vsync       <= !P_VS_POL;
      r_display_on  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_frame_cnt   <= '0;
      r_first       <= 1'b1;
    end else begin
      r_hpos        <= r_h_cnt;
      r_vpos        <= r_v_cnt;
      r_display_on  <= (r_h_cnt < w_ha) && (r_v_cnt < w_va);
      r_hsync       <= w_in_hs ? w_hs_pol : !w_hs_pol;
      r_vsync       <= w_in_vs ? w_vs_pol : !w_vs_pol;
      r_line_start  <= (r_h_cnt == '0);
      r_frame_start <= w_origin;
      // The frame right after reset keeps count 0; later frames advance it
      if (w_origin) begin
        if (r_first) r_first <= 1'b0;
        else         r_frame_cnt <= r_frame_cnt + FCW'(1);
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a small mode so frames stay short.
// A driver issues stimulus on the falling edge and pushes the predicted
// outputs for the next rising edge; a monitor pops and compares after it.
module tb_video_timing_gen;
  localparam int CW   = 8;
  localparam int FCW  = 2;
  localparam int HA0  = 20, HFP0 = 3, HS0 = 4, HBP0 = 5;
  localparam int VA0  = 10, VFP0 = 2, VS0 = 3, VBP0 = 2;
  localparam int HSP0 = 0, VSP0 = 1;
  localparam int W    = 2*CW + FCW + 7;
`ifdef VTG_RUNTIME_CFG_EN
  localparam bit CFG_ON = 1'b1;
`else
  localparam bit CFG_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            hsync, vsync, display_on, line_start, frame_start;
  logic [CW-1:0]   hpos, vpos;
  logic [FCW-1:0]  frame_cnt;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready, cfg_err;
  logic [4*CW-1:0] cfg_h = '0, cfg_v = '0;
  logic [1:0]      cfg_pol = 2'b00;

  video_timing_gen #(
    .CW(CW), .FCW(FCW),
    .H_ACTIVE(HA0), .H_FP(HFP0), .H_SYNC(HS0), .H_BP(HBP0),
    .V_ACTIVE(VA0), .V_FP(VFP0), .V_SYNC(VS0), .V_BP(VBP0),
    .HS_POL(HSP0), .VS_POL(VSP0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol), .cfg_err(cfg_err)
  );

  // Clock
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int phase = 0;
  bit prev_rn = 1'b1;

  // Reference model: linear pixel index within the frame plus timing tables
  int m_t[8];
  int m_pt[8];
  bit m_hp, m_vp, m_php, m_pvp, m_pend;
  int m_n, m_frames;

  function automatic logic [W-1:0] reset_vec();
    return {(HSP0 == 0), (VSP0 == 0), 1'b0, {CW{1'b0}}, {CW{1'b0}},
            2'b00, {FCW{1'b0}}, CFG_ON, 1'b0};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {hsync, vsync, display_on, hpos, vpos, line_start, frame_start,
            frame_cnt, cfg_ready, cfg_err};
  endfunction

  function automatic void model_reset();
    m_t    = '{HA0, HFP0, HS0, HBP0, VA0, VFP0, VS0, VBP0};
    m_hp   = (HSP0 != 0);
    m_vp   = (VSP0 != 0);
    m_pend = 1'b0;
    m_n    = 0;
    m_frames = 0;
  endfunction

  function automatic bit set_ok(input int t[8]);
    return (t[0] != 0) && (t[2] != 0) && (t[4] != 0) && (t[6] != 0)
        && (t[0] + t[1] + t[2] + t[3] < (1 << CW))
        && (t[4] + t[5] + t[6] + t[7] < (1 << CW));
  endfunction

  // Predict the outputs that follow the next rising edge for these inputs
  function automatic void model_step(input bit rn, input bit cv, input logic [4*CW-1:0] h,
                                     input logic [4*CW-1:0] v, input logic [1:0] p);
    int ht, vt, x, y;
    bit hs, vs, don, ls, fs, rdy, err, apply;
    logic [FCW-1:0] fc;
    if (!rn) begin
      model_reset();
      exp_q.push_back(reset_vec());
      return;
    end
    ht  = m_t[0] + m_t[1] + m_t[2] + m_t[3];
    vt  = m_t[4] + m_t[5] + m_t[6] + m_t[7];
    x   = m_n % ht;
    y   = m_n / ht;
    hs  = (x >= m_t[0] + m_t[1] && x < m_t[0] + m_t[1] + m_t[2]) ? m_hp : !m_hp;
    vs  = (y >= m_t[4] + m_t[5] && y < m_t[4] + m_t[5] + m_t[6]) ? m_vp : !m_vp;
    don = (x < m_t[0]) && (y < m_t[4]);
    ls  = (x == 0);
    fs  = (m_n == 0);
    fc  = FCW'(m_frames % (1 << FCW));
    err = 1'b0;
    apply = 1'b0;
    if (CFG_ON) begin
      if (m_n == ht*vt - 1 && m_pend) begin
        if (set_ok(m_pt)) apply = 1'b1;
        else              err = 1'b1;
        m_pend = 1'b0;
      end else if (cv && !m_pend) begin
        for (int i = 0; i < 4; i++) begin
          m_pt[i]   = int'(h[(3-i)*CW +: CW]);
          m_pt[4+i] = int'(v[(3-i)*CW +: CW]);
        end
        m_php  = p[1];
        m_pvp  = p[0];
        m_pend = 1'b1;
      end
      rdy = !m_pend;
    end else begin
      rdy = 1'b0;
    end
    exp_q.push_back({hs, vs, don, CW'(x), CW'(y), ls, fs, fc, rdy, err});
    m_n++;
    if (m_n == ht*vt) begin
      m_n = 0;
      m_frames++;
      if (apply) begin
        m_t  = m_pt;
        m_hp = m_php;
        m_vp = m_pvp;
      end
    end
  endfunction

  // Driver: one clock of stimulus, applied on the falling edge
  task automatic cyc(input bit rn, input bit cv, input logic [4*CW-1:0] h,
                     input logic [4*CW-1:0] v, input logic [1:0] p);
    @(negedge clk);
    reset_n   = rn;
    cfg_valid = cv;
    cfg_h     = h;
    cfg_v     = v;
    cfg_pol   = p;
    model_step(rn, cv, h, v, p);
    if (!rn && prev_rn) begin
      #1;
      n_cmp++;
      if (dut_vec() !== reset_vec()) begin
        n_bad++;
        $display("FAIL async_reset @%0t: got %h required %h", $time, dut_vec(), reset_vec());
      end
    end
    prev_rn = rn;
  endtask

  task automatic rand_set(output logic [4*CW-1:0] h, output logic [4*CW-1:0] v,
                          output logic [1:0] p);
    int ha, hf, hs, hb, va, vf, vs, vb;
    ha = $urandom_range(1, 20); hf = $urandom_range(0, 3);
    hs = $urandom_range(1, 4);  hb = $urandom_range(0, 3);
    va = $urandom_range(1, 8);  vf = $urandom_range(0, 2);
    vs = $urandom_range(1, 3);  vb = $urandom_range(0, 2);
    case ($urandom_range(0, 7))
      0: ha = 0;
      1: vs = 0;
      2: ha = 255;
      default: ;
    endcase
    h = {CW'(ha), CW'(hf), CW'(hs), CW'(hb)};
    v = {CW'(va), CW'(vf), CW'(vs), CW'(vb)};
    p = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n, input bit noise);
    logic [4*CW-1:0] h, v;
    logic [1:0] p;
    for (int i = 0; i < n; i++) begin
      rand_set(h, v, p);
      cyc(1'b1, noise && ($urandom_range(0, 29) == 0), h, v, p);
    end
  endtask

  task automatic offer(input logic [4*CW-1:0] h, input logic [4*CW-1:0] v,
                       input logic [1:0] p, input int hold);
    for (int i = 0; i < hold; i++) cyc(1'b1, 1'b1, h, v, p);
  endtask

  // Scoreboard monitor plus frame period / active-pixel counts for the default mode
  initial begin : monitor
    logic [W-1:0] got, exp;
    int per, don;
    bit have_prev;
    per = 0; don = 0; have_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        got = dut_vec();
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL out @%0t: got %h required %h", $time, got, exp);
        end
      end
      if (phase == 1) begin
        if (frame_start) begin
          if (have_prev) begin
            n_cmp++;
            if (per != (HA0+HFP0+HS0+HBP0)*(VA0+VFP0+VS0+VBP0)) begin
              n_bad++;
              $display("FAIL frame_period: got %0d required %0d", per,
                       (HA0+HFP0+HS0+HBP0)*(VA0+VFP0+VS0+VBP0));
            end
            n_cmp++;
            if (don != HA0*VA0) begin
              n_bad++;
              $display("FAIL active_pixels: got %0d required %0d", don, HA0*VA0);
            end
          end
          have_prev = 1'b1;
          per = 0;
          don = 0;
        end
        per++;
        if (display_on) don++;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  // Stimulus sequence
  initial begin : driver
    bit noise;
    int nr;
    noise = !CFG_ON;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0, 2'b00);
    // Default mode for several frames (frame counter wraps)
    phase = 1;
    idle(5*544 + 10, noise);
    phase = 0;
    // Small valid mode offered mid-frame
    idle(150, noise);
    offer({8'd8, 8'd1, 8'd2, 8'd1}, {8'd4, 8'd1, 8'd1, 8'd1}, 2'b11, 4);
    idle(600 + 3*84, noise);
    // Invalid set: zero active width
    offer({8'd0, 8'd1, 8'd2, 8'd1}, {8'd4, 8'd1, 8'd1, 8'd1}, 2'b00, 3);
    idle(200, noise);
    // Total exactly 2^CW-1 is accepted, 2^CW is rejected
    offer({8'd250, 8'd0, 8'd5, 8'd0}, {8'd1, 8'd0, 8'd1, 8'd0}, 2'b10, 2);
    idle(200, noise);
    offer({8'd250, 8'd0, 8'd6, 8'd0}, {8'd1, 8'd0, 8'd1, 8'd0}, 2'b01, 2);
    idle(1100, noise);
    // Reset while a set is pending: the set is dropped, defaults resume
    offer({8'd10, 8'd1, 8'd2, 8'd1}, {8'd5, 8'd1, 8'd1, 8'd1}, 2'b11, 2);
    idle(5, noise);
    cyc(1'b0, 1'b0, '0, '0, 2'b00);
    cyc(1'b0, 1'b0, '0, '0, 2'b00);
    idle(1200, noise);
    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        nr = $urandom_range(1, 3);
        for (int k = 0; k < nr; k++) cyc(1'b0, 1'b0, '0, '0, 2'b00);
      end else begin
        idle(1, 1'b1);
      end
    end
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
